muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Execute-stage HI/LO multiply/divide unit for the pipelined MIPS core. It consumes the two register-file read operands after forwarding, the same values that feed the ALU. It runs MULT/MULTU/DIV/DIVU iteratively and holds the architectural HI/LO registers that MFHI/MFLO read. It raises busy so the hazard unit can stall dependent HI/LO accesses.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold XLEN+1.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, launch the operation selected by op; sampled only in IDLE.
- op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca, input, XLEN, rs operand (dividend/multiplicand); also the MTHI/MTLO data.
- srcb, input, XLEN, rt operand (divisor/multiplier).
- mthi, input, 1, write srca to HI; honoured only in IDLE.
- mtlo, input, 1, write srca to LO; honoured only in IDLE.
- flush, input, 1, abort any in-flight operation.
- busy, output, 1, high whenever state != IDLE (registered).
- done, output, 1, one-cycle pulse after HI/LO take a result.
- hi, output, XLEN, HI register.
- lo, output, XLEN, LO register.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operands cleared. Deasserting reset mid-operation leaves no residue of the aborted operation.
- States: IDLE -> MUL or DIV on start -> FIX -> IDLE.
- IDLE, start=1 at edge k:
  - Latch |srca| and |srcb| for signed ops, raw values for unsigned ops.
  - Record result signs: quotient/product sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Clear counter; go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: shift-add, one multiplier bit per cycle, 2*XLEN accumulator. Edges k+1..k+32 perform the 32 iterations; then go to FIX.
- DIV: restoring division, one quotient bit per cycle. Edges k+1..k+32; then go to FIX.
- FIX (edge k+33):
  - Apply two's-complement sign correction.
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
  - done=1 for exactly the following cycle; return to IDLE.
- Latency: busy is 1 for cycles following edges k .. k+32 (33 cycles). New HI/LO values are visible after edge k+33.
- Divide by zero (srcb=0, DIV or DIVU): no trap. Result is lo=0xFFFFFFFF, hi=srca (original signed value); same 34-edge latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Remainder is zero or has the sign of the dividend; the quotient truncates toward zero.
- start while busy: ignored. No queueing, no effect on the running op.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: update the register at the next edge; both may be set in the same cycle.
- start together with mthi/mtlo in IDLE: start wins; the move is dropped.
- flush:
  - Has priority over all other inputs.
  - Any state goes to IDLE at the next edge; hi/lo keep their pre-start values; done stays 0.
  - A start in the same cycle as flush is discarded.
- FIX with flush asserted: flush wins; no HI/LO write, no done.
- Write ordering: the register file writes on the falling edge; this block is rising-edge only, with no combinational path from inputs to hi/lo/busy/done.

Decomposition:
- Shared definitions header muldiv_defs:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - State encodings S_IDLE/S_MUL/S_DIV/S_FIX.
  - ITER=32.
- One natural sub-module: div_iter, the restoring-division datapath step (remainder/quotient shift-subtract, one bit per enable). Multiply datapath and control stay in muldiv_unit.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> after edge k+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles; done single pulse.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi srca=0x12345678, then MULTU 5x6 with flush at edge k+10, then start raised again during flush:
  - required: hi=0x12345678, lo=0 unchanged; busy=0 after the flush edge; done never pulses.
  - reset_n pulsed low mid-DIV -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// controller states and the iteration count.
package muldiv_unit_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;
    localparam int ITER      = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            mthi;
    logic            mtlo;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, srca, srcb, mthi, mtlo, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, mthi, mtlo, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring-division step: shifts one dividend bit into the partial remainder
// per enable and records one quotient bit.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_clr,
    input  logic            i_load,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN:0]   w_shift;
    logic            w_fits;
    logic [XLEN-1:0] w_sub;

    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_fits  = (w_shift >= {1'b0, r_divisor});
    assign w_sub   = XLEN'(w_shift - {1'b0, r_divisor});

    // Quotient/remainder registers; clear beats load beats step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quot    <= {XLEN{1'b0}};
            r_rem     <= {XLEN{1'b0}};
            r_divisor <= {XLEN{1'b0}};
        end else if (i_clr) begin
            r_quot    <= {XLEN{1'b0}};
            r_rem     <= {XLEN{1'b0}};
            r_divisor <= {XLEN{1'b0}};
        end else if (i_load) begin
            r_quot    <= i_dividend;
            r_rem     <= {XLEN{1'b0}};
            r_divisor <= i_divisor;
        end else if (i_en) begin
            r_quot    <= {r_quot[XLEN-2:0], w_fits};
            r_rem     <= w_fits ? w_sub : w_shift[XLEN-1:0];
            r_divisor <= r_divisor;
        end else begin
            r_quot    <= r_quot;
            r_rem     <= r_rem;
            r_divisor <= r_divisor;
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on launch and sign-corrected in FIX.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_opa;
    logic [2*XLEN-1:0] r_acc;
    logic              r_is_div;
    logic              r_q_neg;
    logic              r_r_neg;
    logic              r_div0;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_launch;
    logic              w_last;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res_hi;
    logic [XLEN-1:0]   w_res_lo;

    assign w_signed  = ~bus.op[0];
    assign w_a_neg   = w_signed & bus.srca[XLEN-1];
    assign w_b_neg   = w_signed & bus.srcb[XLEN-1];
    assign w_abs_a   = w_a_neg ? -bus.srca : bus.srca;
    assign w_abs_b   = w_b_neg ? -bus.srcb : bus.srcb;
    assign w_launch  = (r_state == S_IDLE) & bus.start;
    assign w_last    = (r_cnt == CNT_W'(ITER - 1));
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + {1'b0, (r_acc[0] ? r_opa : {XLEN{1'b0}})};

    div_iter #(.XLEN(XLEN)) u_div_iter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (bus.flush),
        .i_load     (w_launch),
        .i_en       (r_state == S_DIV),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Next-state selection; flush forces IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = bus.start ? (bus.op[1] ? S_DIV : S_MUL) : S_IDLE;
                S_MUL:   w_state_nxt = w_last ? S_FIX : S_MUL;
                S_DIV:   w_state_nxt = w_last ? S_FIX : S_DIV;
                S_FIX:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Sign-corrected result; a zero divisor returns all-ones and the dividend.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        if (r_is_div) begin
            if (r_div0) begin
                w_res_lo = {XLEN{1'b1}};
                w_res_hi = r_r_neg ? -r_opa : r_opa;
            end else begin
                w_res_lo = r_q_neg ? -w_quot : w_quot;
                w_res_hi = r_r_neg ? -w_rem : w_rem;
            end
        end else begin
            {w_res_hi, w_res_lo} = r_q_neg ? -r_acc : r_acc;
        end
    end

    // Controller state, iteration counter, result signs and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_is_div <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.flush) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_is_div <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_FIX);
            if (w_launch) begin
                r_cnt    <= {CNT_W{1'b0}};
                r_is_div <= bus.op[1];
                r_q_neg  <= w_a_neg ^ w_b_neg;
                r_r_neg  <= w_a_neg;
                r_div0   <= bus.op[1] & (bus.srcb == {XLEN{1'b0}});
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Multiply accumulator, latched multiplicand and the HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opa <= {XLEN{1'b0}};
            r_acc <= {(2*XLEN){1'b0}};
            r_hi  <= {XLEN{1'b0}};
            r_lo  <= {XLEN{1'b0}};
        end else if (bus.flush) begin
            r_opa <= {XLEN{1'b0}};
            r_acc <= {(2*XLEN){1'b0}};
            r_hi  <= r_hi;
            r_lo  <= r_lo;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_opa <= w_abs_a;
                        r_acc <= {{XLEN{1'b0}}, w_abs_b};
                    end else begin
                        if (bus.mthi) r_hi <= bus.srca;
                        else          r_hi <= r_hi;
                        if (bus.mtlo) r_lo <= bus.srca;
                        else          r_lo <= r_lo;
                    end
                end
                S_MUL: r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                S_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: r_acc <= r_acc;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
